// File: rtl/vector_load_assembler.sv
// vector_load_assembler
//
// Loads NUM_WORDS 32-bit words from data memory, one read at a time, into a
// shadow buffer. The assembled vector is published on vec_out all at once, so
// downstream logic never sees a partially loaded vector.
//
// Optional feature: define VLOAD_TIMEOUT_EN to add a 4-bit WAIT watchdog.
// After 15 consecutive WAIT cycles without mem_rvalid, the load is abandoned
// and err is raised. Without the macro, err is tied to 0 and WAIT can last
// indefinitely.
//
// Ports
//   clk         clock; all state changes on the rising edge
//   rst         synchronous active-high reset
//   start       load request; only accepted in IDLE
//   base_addr   byte address of word 0; captured with an accepted start
//   mem_rd_en   one-cycle read request (REQ state)
//   mem_addr    read address, base + idx*ADDR_STRIDE (mod 2^32) while
//               mem_rd_en=1, otherwise 0
//   mem_rdata   read data, qualified by mem_rvalid
//   mem_rvalid  read-data strobe; only honoured in WAIT
//   busy        high in REQ, WAIT and DONE
//   done        one-cycle pulse in DONE
//   err         timeout flag (VLOAD_TIMEOUT_EN only, otherwise 0)
//   vec_out     assembled vector, word k at bits [32k+31:32k]
module vector_load_assembler #(
  parameter int NUM_WORDS   = 6,
  parameter int ADDR_STRIDE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             base_addr,
  output logic                    mem_rd_en,
  output logic [31:0]             mem_addr,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_rvalid,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [NUM_WORDS*32-1:0] vec_out
);

  localparam int DATA_W = 32;
  localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  logic [1:0]                          state;
  logic [IDX_W-1:0]                    idx;
  logic [DATA_W-1:0]                   base;
  logic [NUM_WORDS-1:0][DATA_W-1:0]    shadow;
  logic [NUM_WORDS-1:0][DATA_W-1:0]    shadow_nxt;
  logic                                timeout_hit;

  // The last word is captured on the same edge that enters DONE, so vec_out
  // is loaded from the shadow buffer with the incoming word merged in.
  always_comb begin
    shadow_nxt      = shadow;
    shadow_nxt[idx] = mem_rdata;
  end

  assign mem_rd_en = (state == S_REQ);
  assign mem_addr  = (state == S_REQ) ?
                     base + 32'(idx) * 32'(ADDR_STRIDE) : '0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

`ifdef VLOAD_TIMEOUT_EN
  logic [3:0] wait_cnt;

  // wait_cnt is 0 in the first WAIT cycle, so a value of 14 marks the 15th
  // consecutive WAIT cycle without a response.
  assign timeout_hit = (state == S_WAIT) && !mem_rvalid && (wait_cnt == 4'd14);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state != S_WAIT) begin
        wait_cnt <= '0;
      end else if (!mem_rvalid) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (state == S_IDLE && start) begin
        err <= 1'b0;
      end else if (timeout_hit) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      base    <= '0;
      shadow  <= '0;
      vec_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base  <= base_addr;
            idx   <= '0;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            shadow <= shadow_nxt;
            if (idx == LAST_IDX) begin
              vec_out <= shadow_nxt;
              state   <= S_DONE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= S_REQ;
            end
          end else if (timeout_hit) begin
            // Abandoned load: vec_out keeps the previously published vector.
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_load_assembler.sv
// Testbench for vector_load_assembler: directed scenarios plus randomized
// loads, checked against a reference model of the expected addresses,
// assembled vector and timing derived from the load rules.
module tb_vector_load_assembler;

  localparam int NW = 6;
  localparam int VW = NW * 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   base_addr = '0;
  logic          mem_rd_en;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_rdata = '0;
  logic          mem_rvalid = 1'b0;
  logic          busy;
  logic          done;
  logic          err;
  logic [VW-1:0] vec_out;

  vector_load_assembler #(.NUM_WORDS(NW), .ADDR_STRIDE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .vec_out    (vec_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: records every read request, answers each one rsp_delay
  // cycles later (0 = never), optionally with a stray rvalid in the REQ cycle.
  logic [31:0] resp_data [NW];
  logic [31:0] addr_q [$];
  int          rsp_delay = 1;
  bit          stray = 1'b0;
  int          wait_n = 0;

  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (wait_n > 0) begin
      wait_n--;
      if (wait_n == 0 && addr_q.size() >= 1 && addr_q.size() <= NW) begin
        mem_rvalid = 1'b1;
        mem_rdata  = resp_data[addr_q.size() - 1];
      end
    end
    if (mem_rd_en === 1'b1) begin
      addr_q.push_back(mem_addr);
      if (rsp_delay > 0) wait_n = rsp_delay;
      if (stray) begin
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
      end
    end
  end

  function automatic logic [VW-1:0] model_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < NW; k++) v[32*k +: 32] = resp_data[k];
    return v;
  endfunction

  // Runs one complete load starting at a negedge; poke drives a competing
  // start with base 0x200 during WAIT of word 2.
  task automatic do_load(input string tag, input logic [31:0] b, input int dly,
                         input bit str, input bit poke);
    logic [VW-1:0] prev, expv;
    logic [31:0]   expa;
    int  cyc;
    bit  got, busy_ok, stable_ok, idle_ok;
    prev = vec_out;
    expv = model_vec();
    addr_q.delete();
    rsp_delay = dly;
    stray     = str;
    base_addr = b;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    base_addr = $urandom;
    cyc = 1; got = 0; busy_ok = 1; stable_ok = 1;
    while (!got && cyc < 400) begin
      if (busy !== 1'b1) busy_ok = 0;
      if (done === 1'b1) got = 1;
      else if (vec_out !== prev) stable_ok = 0;
      if (poke && cyc == 6) begin
        start = 1'b1; base_addr = 32'h200;
      end else if (poke && cyc == 7) begin
        start = 1'b0;
      end
      if (!got) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk({tag, " done_seen"}, VW'(got), VW'(1'b1));
    chk({tag, " latency"}, VW'(cyc), VW'(NW * (dly + 1) + 1));
    chk({tag, " busy_held"}, VW'(busy_ok), VW'(1'b1));
    chk({tag, " no_partial"}, VW'(stable_ok), VW'(1'b1));
    chk({tag, " vec_out"}, vec_out, expv);
    chk({tag, " err"}, VW'(err), VW'(1'b0));
    chk({tag, " nreads"}, VW'(addr_q.size()), VW'(NW));
    for (int k = 0; k < NW && k < addr_q.size(); k++) begin
      expa = b + 32'(4 * k);
      chk({tag, " addr"}, VW'(addr_q[k]), VW'(expa));
    end
    @(negedge clk);
    chk({tag, " done_pulse"}, VW'(done), VW'(1'b0));
    idle_ok = 1;
    for (int i = 0; i < 3; i++) begin
      if (busy !== 1'b0 || done !== 1'b0) idle_ok = 0;
      @(negedge clk);
    end
    chk({tag, " idle_after"}, VW'(idle_ok), VW'(1'b1));
    chk({tag, " vec_hold"}, vec_out, expv);
  endtask

  initial begin
    logic [VW-1:0] prev;
    int  cyc;
    bit  done_seen;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst busy", VW'(busy), VW'(1'b0));
    chk("rst done", VW'(done), VW'(1'b0));
    chk("rst err", VW'(err), VW'(1'b0));
    chk("rst rd_en", VW'(mem_rd_en), VW'(1'b0));
    chk("rst addr", VW'(mem_addr), VW'(32'h0));
    chk("rst vec", vec_out, '0);
    rst = 1'b0;
    @(negedge clk);

    // Basic load
    for (int k = 0; k < NW; k++) resp_data[k] = 32'hA0 + 32'(k);
    do_load("basic", 32'h100, 1, 1'b0, 1'b0);
    chk("basic word0", VW'(vec_out[31:0]), VW'(32'hA0));
    chk("basic word5", VW'(vec_out[191:160]), VW'(32'hA5));

    // Wait states
    for (int k = 0; k < NW; k++) resp_data[k] = 32'hB0 + 32'(k);
    do_load("wait3", 32'h100, 3, 1'b0, 1'b0);

    // Start while busy
    for (int k = 0; k < NW; k++) resp_data[k] = 32'hA0 + 32'(k);
    do_load("poke", 32'h100, 1, 1'b0, 1'b1);

    // Wrap-around
    for (int k = 0; k < NW; k++) resp_data[k] = $urandom;
    do_load("wrap", 32'hFFFF_FFF8, 1, 1'b1, 1'b0);
    if (addr_q.size() == NW) chk("wrap addr2", VW'(addr_q[2]), VW'(32'h0));

    // Reset mid-operation in WAIT of word 4
    for (int k = 0; k < NW; k++) resp_data[k] = $urandom;
    addr_q.delete();
    rsp_delay = 1; stray = 1'b0;
    base_addr = 32'h100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_seen = 0;
    for (cyc = 1; cyc < 10; cyc++) begin
      if (done === 1'b1) done_seen = 1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", VW'(busy), VW'(1'b0));
    chk("midrst vec", vec_out, '0);
    chk("midrst rd_en", VW'(mem_rd_en), VW'(1'b0));
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1 || busy === 1'b1) done_seen = 1;
      @(negedge clk);
    end
    chk("midrst no_done", VW'(done_seen), VW'(1'b0));
    for (int k = 0; k < NW; k++) resp_data[k] = $urandom;
    do_load("after_rst", 32'h100, 1, 1'b0, 1'b0);

    // Randomized loads
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < NW; k++) resp_data[k] = $urandom;
      do_load("rand", $urandom, $urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Missing response
    prev = vec_out;
    addr_q.delete();
    rsp_delay = 0; stray = 1'b0;
    base_addr = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; done_seen = 0;
`ifdef VLOAD_TIMEOUT_EN
    while (busy === 1'b1 && cyc < 60) begin
      if (done === 1'b1) done_seen = 1;
      @(negedge clk);
      cyc++;
    end
    chk("tmo cycle", VW'(cyc), VW'(2 + 15));
    chk("tmo err", VW'(err), VW'(1'b1));
    chk("tmo vec", vec_out, prev);
    chk("tmo no_done", VW'(done_seen), VW'(1'b0));
    for (int k = 0; k < NW; k++) resp_data[k] = $urandom;
    do_load("after_tmo", $urandom, 1, 1'b0, 1'b0);
`else
    while (cyc < 40) begin
      if (done === 1'b1) done_seen = 1;
      @(negedge clk);
      cyc++;
    end
    chk("hang busy", VW'(busy), VW'(1'b1));
    chk("hang err", VW'(err), VW'(1'b0));
    chk("hang vec", vec_out, prev);
    chk("hang no_done", VW'(done_seen), VW'(1'b0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("hang rst busy", VW'(busy), VW'(1'b0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_load_assembler.md
VECTOR_LOAD_ASSEMBLER -- requirements
Module: vector_load_assembler

Interface
REQ-001 Parameter NUM_WORDS, default 6, number of 32-bit words per vector.
REQ-002 Parameter ADDR_STRIDE, default 4, byte increment between successive word addresses.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  request to load one vector; sampled in IDLE only.
REQ-006 base_addr  input  32  byte address of word 0; sampled with accepted start.
REQ-007 mem_rd_en  output  1  one-cycle read request to data memory.
REQ-008 mem_addr  output  32  read address, valid when mem_rd_en=1.
REQ-009 mem_rdata  input  32  read data, valid when mem_rvalid=1.
REQ-010 mem_rvalid  input  1  read-data strobe from memory.
REQ-011 busy  output  1  high from the cycle after accepted start until DONE is left.
REQ-012 done  output  1  one-cycle pulse in the DONE state.
REQ-013 err  output  1  timeout flag; present only with VLOAD_TIMEOUT_EN and tied 0 otherwise.
REQ-014 vec_out  output  NUM_WORDS*32 (192)  assembled vector, feeding the 192-bit input of the writeback 4-to-1 mux.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT and DONE.
REQ-016 In IDLE with start=1, the block SHALL latch base_addr, clear word index idx to 0 and go to REQ; with start=0 it SHALL stay in IDLE.
REQ-017 In REQ, the block SHALL drive mem_rd_en=1 and mem_addr=base+idx*ADDR_STRIDE (mod 2^32) for exactly one cycle, then go to WAIT.
REQ-018 In WAIT with mem_rvalid=1, the block SHALL write mem_rdata into shadow slot idx (bits [32*idx+31:32*idx]).
- If idx=NUM_WORDS-1: go to DONE.
- Otherwise: increment idx and go to REQ.
REQ-019 In WAIT with mem_rvalid=0, the block SHALL hold state, and mem_rd_en SHALL be 0.
REQ-020 Minimum latency from accepted start to done SHALL be 2*NUM_WORDS+1 cycles (13 for the default) with single-cycle memory response.
REQ-021 On entry to DONE, vec_out SHALL be updated from the shadow buffer in one step, done=1 for one cycle, and the next state SHALL be IDLE.
REQ-022 vec_out SHALL be stable between DONE entries, and SHALL never expose a partially assembled vector.
REQ-023 start SHALL be ignored in REQ, WAIT and DONE, and SHALL not queue.
REQ-024 mem_rvalid SHALL be ignored outside WAIT.
REQ-025 Address arithmetic SHALL wrap modulo 2^32 without flagging an error.

Reset
REQ-026 With rst=1 at a rising edge, the block SHALL enter IDLE and clear idx, the shadow buffer, vec_out, mem_addr, mem_rd_en, busy, done and err to 0.
REQ-027 Reset SHALL take priority over start and mem_rvalid in the same cycle.
REQ-028 Reset mid-load SHALL abort the load without asserting done.

Configuration
REQ-029 With macro VLOAD_TIMEOUT_EN defined, a 4-bit counter SHALL count consecutive WAIT cycles.
- On reaching 15 without mem_rvalid, the block SHALL set err=1, go to IDLE without done, and leave vec_out unchanged.
- err SHALL clear on the next accepted start or on reset.
REQ-030 Without VLOAD_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL last indefinitely, and err SHALL be constant 0.

Verification
REQ-031 Basic load: base_addr=0x100; memory returns 0xA0+k at address 0x100+4k with 1-cycle rvalid -> mem_addr sequence 0x100,0x104,...,0x114; done at cycle 13; vec_out[31:0]=0xA0 and vec_out[191:160]=0xA5.
REQ-032 Wait states: memory delays each rvalid by 3 cycles -> same vec_out as REQ-031; busy held throughout; done exactly once.
REQ-033 Start while busy: pulse start with base_addr=0x200 during WAIT of word 2 -> no effect; result and addresses match the 0x100 load.
REQ-034 Reset mid-operation: rst=1 in WAIT of word 4 -> next cycle IDLE, vec_out=0, done never asserted; a fresh start then loads correctly.
REQ-035 Wrap-around: base_addr=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, 0x8, 0xC.
REQ-036 Timeout (VLOAD_TIMEOUT_EN defined): no rvalid for word 0 -> err=1 after 15 WAIT cycles, IDLE, vec_out keeps prior value; without the macro the block stays in WAIT and err=0.
